// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory image loader.
package loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_e;

  // Number of header bytes carrying the word count (LEN_LO, LEN_HI)
  localparam int HDR_BYTES = 2;

  // States in which a load is in progress
  function automatic logic is_busy(input state_e s);
    return (s inside {HDR_LO, HDR_HI, DATA, WRITE, CHK});
  endfunction

  // States that accept stream bytes (the idle timeout also runs only here)
  function automatic logic is_receiving(input state_e s);
    return (s inside {HDR_LO, HDR_HI, DATA, CHK});
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: collects four little-endian bytes into a 32-bit
// word and keeps a running XOR of every byte it accepts.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o,
  output logic [7:0]  chk_o
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic [7:0]  r_chk;
  logic [31:0] w_word_nxt;

  // Bytes enter at the top and shift down, so byte k ends in bits [8k+7:8k]
  assign w_word_nxt  = {byte_i, r_word[31:8]};
  assign word_o      = w_word_nxt;
  assign word_full_o = (r_cnt == 2'd3);
  assign chk_o       = r_chk;

  // Byte counter, shift register and running checksum
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
      r_chk  <= 8'd0;
    end else if (clear_i) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
      r_chk  <= 8'd0;
    end else if (accept_i) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= w_word_nxt;
      r_chk  <= r_chk ^ byte_i;
    end else begin
      r_cnt  <= r_cnt;
      r_word <= r_word;
      r_chk  <= r_chk;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checked byte
// stream, writes 32-bit words into imem and holds the core in reset until a
// complete image with a matching checksum has been written.
module imem_loader
  import loader_pkg::*;
#(
  parameter int IMEM_W      = 13,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [IMEM_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_rst_o
);

  localparam int IDX_W = IMEM_W - 1;
  localparam int DEPTH = 2 ** (IMEM_W - 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [8*HDR_BYTES-1:0]   r_len;
  logic [IDX_W-1:0]         r_idx;
  logic [TMO_W-1:0]         r_tmo;
  logic [IMEM_W-1:0]        r_waddr;
  logic [31:0]              r_wdata;

  logic                     w_accept;
  logic                     w_start;
  logic [15:0]              w_len_full;
  logic                     w_len_too_big;
  logic                     w_last_word;
  logic                     w_tmo_hit;
  logic                     w_asm_accept;
  logic [31:0]              w_word;
  logic                     w_word_full;
  logic [7:0]               w_chk;

  assign w_accept      = byte_valid_i & byte_ready_o;
  assign w_start       = start_i & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));
  assign w_len_full    = {byte_data_i, r_len[7:0]};
  assign w_len_too_big = (17'(w_len_full) > 17'(DEPTH));
  assign w_last_word   = ((17'(r_idx) + 17'd1) == 17'(r_len));
  assign w_tmo_hit     = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_asm_accept  = w_accept & (r_state == DATA);
  assign waddr_o       = r_waddr;
  assign wdata_o       = r_wdata;

  loader_word_asm u_word_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (w_start),
    .accept_i    (w_asm_accept),
    .byte_i      (byte_data_i),
    .word_o      (w_word),
    .word_full_o (w_word_full),
    .chk_o       (w_chk)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an accepted byte takes priority over an expiring timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_state_nxt = HDR_LO;
        else         w_state_nxt = IDLE;
      end
      HDR_LO: begin
        if (w_accept)       w_state_nxt = HDR_HI;
        else if (w_tmo_hit) w_state_nxt = ERR;
        else                w_state_nxt = HDR_LO;
      end
      HDR_HI: begin
        if (w_accept) begin
          if (w_len_full == 16'd0) w_state_nxt = CHK;
          else if (w_len_too_big)  w_state_nxt = ERR;
          else                     w_state_nxt = DATA;
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
        end else begin
          w_state_nxt = HDR_HI;
        end
      end
      DATA: begin
        if (w_accept) begin
          if (w_word_full) w_state_nxt = WRITE;
          else             w_state_nxt = DATA;
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
        end else begin
          w_state_nxt = DATA;
        end
      end
      WRITE: begin
        if (w_last_word) w_state_nxt = CHK;
        else             w_state_nxt = DATA;
      end
      CHK: begin
        if (w_accept) begin
          if (byte_data_i == w_chk) w_state_nxt = DONE;
          else                      w_state_nxt = ERR;
        end else if (w_tmo_hit) begin
          w_state_nxt = ERR;
        end else begin
          w_state_nxt = CHK;
        end
      end
      DONE: begin
        if (start_i) w_state_nxt = HDR_LO;
        else         w_state_nxt = DONE;
      end
      ERR: begin
        if (start_i) w_state_nxt = HDR_LO;
        else         w_state_nxt = ERR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    byte_ready_o = 1'b0;
    we_o         = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    cpu_rst_o    = 1'b1;
    case (r_state)
      HDR_LO, HDR_HI, DATA, CHK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      WRITE: begin
        we_o   = 1'b1;
        busy_o = 1'b1;
      end
      DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = 1'b0;
      end
      ERR: begin
        err_o = 1'b1;
      end
      default: begin
        byte_ready_o = 1'b0;
      end
    endcase
  end

  // Header length capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len <= '0;
    end else if (w_start) begin
      r_len <= '0;
    end else if (w_accept && (r_state == HDR_LO)) begin
      r_len[7:0] <= byte_data_i;
    end else if (w_accept && (r_state == HDR_HI)) begin
      r_len[15:8] <= byte_data_i;
    end else begin
      r_len <= r_len;
    end
  end

  // Word index: advances once per imem write, wide enough to hold DEPTH
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx <= '0;
    end else if (w_start) begin
      r_idx <= '0;
    end else if (r_state == WRITE) begin
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Write address/data registers, loaded as the 4th byte of a word arrives
  // so they line up with the WRITE cycle and hold afterwards
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_waddr <= '0;
      r_wdata <= 32'd0;
    end else if (w_asm_accept && w_word_full) begin
      r_waddr <= {r_idx[IMEM_W-3:0], 2'b00};
      r_wdata <= w_word;
    end else begin
      r_waddr <= r_waddr;
      r_wdata <= r_wdata;
    end
  end

  // Idle timeout: cleared by any accepted byte and outside receiving states
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tmo <= '0;
    end else if (w_accept || !is_receiving(r_state)) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are issued by a driver, an
// independent frame model predicts the imem writes and final outcome, and a
// monitor compares every we_o pulse against the predicted write queue.
module tb_imem_loader;

  localparam int IMEM_W = 13;
  localparam int TMO    = 16;
  localparam int DEPTH  = 2048;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [IMEM_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              we_o;
  logic [IMEM_W-1:0] waddr_o;
  logic [31:0]       wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              cpu_rst_o;

  int                checks   = 0;
  int                failures = 0;
  int                n_we     = 0;
  logic [IMEM_W-1:0] last_addr = '0;
  wr_t               exp_q[$];

  imem_loader #(.IMEM_W(IMEM_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_rst_o    (cpu_rst_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest predicted write
  always @(negedge clk_i) begin
    wr_t e;
    if (we_o === 1'b1) begin
      n_we++;
      last_addr = waddr_o;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h required=none", waddr_o);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 32'(waddr_o), 32'(e.addr));
        check("wdata", wdata_o, e.data);
      end
    end
  end

  // Reference model: decode a frame into its writes, bytes consumed and outcome
  function automatic void model(input bq_t fr, output int n, output bit ok);
    int         len;
    logic [7:0] chk;
    logic [31:0] word;
    len = int'({fr[1], fr[0]});
    ok  = 1'b0;
    if (len > DEPTH) begin
      n = 2;
      return;
    end
    chk = 8'h00;
    for (int w = 0; w < len; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        word = word | (32'(fr[2 + 4*w + k]) << (8*k));
        chk  = chk ^ fr[2 + 4*w + k];
      end
      exp_q.push_back('{addr: IMEM_W'(4*w), data: word});
    end
    n  = 2 + 4*len + 1;
    ok = (fr[n-1] == chk);
  endfunction

  function automatic bq_t build(input int len, input bit good);
    bq_t        q;
    logic [7:0] b;
    logic [7:0] chk;
    logic [15:0] l16;
    l16 = 16'(len);
    chk = 8'h00;
    q.push_back(l16[7:0]);
    q.push_back(l16[15:8]);
    for (int i = 0; i < 4*len; i++) begin
      b = 8'($urandom);
      chk = chk ^ b;
      q.push_back(b);
    end
    if (good) q.push_back(chk);
    else      q.push_back(chk ^ 8'($urandom_range(1, 255)));
    return q;
  endfunction

  task automatic pulse_start();
    byte_valid_i = 1'b0;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
  endtask

  // Present one byte (after optional random stall) until it is accepted
  task automatic send_byte(input logic [7:0] b, input int stall);
    int   n;
    logic r;
    logic acc;
    if (stall > 0) begin
      n = $urandom_range(0, stall);
      repeat (n) begin
        byte_valid_i = 1'b0;
        @(negedge clk_i);
      end
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    acc = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (!acc) begin
        r = byte_ready_o;
        @(negedge clk_i);
        if (r) acc = 1'b1;
      end
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept actual=not_accepted required=accepted");
    end
  endtask

  // Drive a whole frame; optionally poke start_i while busy before byte 'poke'
  task automatic run_frame(input bq_t fr, input int stall, input int poke, input string tag);
    int n;
    bit ok;
    model(fr, n, ok);
    pulse_start();
    for (int i = 0; i < n; i++) begin
      if (i == poke) begin
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        @(negedge clk_i);
        start_i      = 1'b0;
      end
      send_byte(fr[i], stall);
    end
    byte_valid_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!(done_o || err_o)) @(negedge clk_i);
    end
    check({tag, "_done"}, 32'(done_o), 32'(ok));
    check({tag, "_err"}, 32'(err_o), 32'(!ok));
    check({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'(!ok));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t fr;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    #1;
    check("rst_ready", 32'(byte_ready_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed two-word image, good and bad checksum
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    run_frame(fr, 0, -1, "two_word_ok");
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 1, -1, "two_word_badchk");

    // Oversized length: error straight after the header, no writes
    n_we = 0;
    fr = '{8'h01, 8'h08};
    run_frame(fr, 0, -1, "len_2049");
    check("len_2049_writes", 32'(n_we), 32'd0);

    // Empty images
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(fr, 0, -1, "empty_ok");
    fr = '{8'h00, 8'h00, 8'h01};
    run_frame(fr, 0, -1, "empty_badchk");

    // Idle timeout after two data bytes
    n_we = 0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    byte_valid_i = 1'b0;
    repeat (TMO - 1) @(negedge clk_i);
    check("tmo_before", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check("tmo_at", 32'(err_o), 32'd1);
    check("tmo_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("tmo_writes", 32'(n_we), 32'd0);

    // Random images with random stalls and random checksum corruption
    for (int t = 0; t < 8; t++) begin
      fr = build($urandom_range(0, 6), ($urandom_range(0, 3) != 0));
      run_frame(fr, 3, -1, "random");
    end

    // start_i while busy must be ignored
    fr = build(3, 1'b1);
    run_frame(fr, 2, 5, "start_busy");

    // Reset in the middle of DATA
    fr = build(2, 1'b1);
    run_frame(fr, 0, -1, "pre_reset");
    n_we = 0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_i = 1'b1;
    #1;
    check("midrst_ready", 32'(byte_ready_o), 32'd0);
    check("midrst_we", 32'(we_o), 32'd0);
    check("midrst_waddr", 32'(waddr_o), 32'd0);
    check("midrst_wdata", wdata_o, 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    byte_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("midrst_writes", 32'(n_we), 32'd0);
    check("midrst_idle_busy", 32'(busy_o), 32'd0);

    // Full-memory image with byte_valid_i held high throughout
    fr = build(DEPTH, 1'b1);
    run_frame(fr, 0, -1, "full_image");
    check("full_last_waddr", 32'(last_addr), 32'h0000_1FFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
